// File: rtl/vec_mem_pkg.sv
// Shared definitions for the vector memory-stage sequencer.
//   - vm_state_e : sequencer FSM states
//   - VM_*       : default geometry (lanes, lane width, address width)
//   - lane_lsb() : bit offset of a lane inside a packed lane vector
package vec_mem_pkg;

  localparam int VM_LANES  = 4;
  localparam int VM_DATA_W = 8;
  localparam int VM_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } vm_state_e;

  // Lane k of a packed vector occupies [k*data_w +: data_w].
  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/vector_mem_sequencer.sv
// Memory-stage sequencer. It serialises scalar and vector loads and stores
// onto a single-port, lane-wide data memory, one lane per cycle. It holds
// Mem_Finished_o low until every lane has completed.
//
// Ports:
//   Clk_i, Rst_i       clock, synchronous active-high reset
//   Start_i, MemOp_i   instruction present / instruction is a load or store
//   MemWE_i            1 = store, 0 = load
//   Vector_i           1 = LANES-element access, 0 = scalar (lane 0)
//   Addr_i, WData_i    base address and store data (latched at acceptance)
//   DMem*_o            memory address / write enable / read enable / write data
//   DMemRData_i        read data, valid the cycle after DMemRE_o
//   RData_o            registered load result
//   Mem_Finished_o     memory stage complete; pipeline may advance
module vector_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int LANES  = VM_LANES,
  parameter int DATA_W = VM_DATA_W,
  parameter int ADDR_W = VM_ADDR_W
) (
  input  logic                    Clk_i,
  input  logic                    Rst_i,
  input  logic                    Start_i,
  input  logic                    MemOp_i,
  input  logic                    MemWE_i,
  input  logic                    Vector_i,
  input  logic [ADDR_W-1:0]       Addr_i,
  input  logic [LANES*DATA_W-1:0] WData_i,
  output logic [ADDR_W-1:0]       DMemAddr_o,
  output logic                    DMemWE_o,
  output logic                    DMemRE_o,
  output logic [DATA_W-1:0]       DMemWData_o,
  input  logic [DATA_W-1:0]       DMemRData_i,
  output logic [LANES*DATA_W-1:0] RData_o,
  output logic                    Mem_Finished_o
);

  localparam int CNT_W = $clog2(LANES);

  vm_state_e state_reg, state_next;

  logic [CNT_W-1:0]        lane_cnt_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic [LANES*DATA_W-1:0] wdata_reg;
  logic                    we_reg;
  logic                    vec_reg;
  logic [LANES*DATA_W-1:0] rdata_reg;

  // Read data returns one cycle after the read strobe, so the lane that is
  // to be captured is remembered for one cycle.
  logic                    cap_pend_reg;
  logic [CNT_W-1:0]        cap_lane_reg;
  logic                    cap_scalar_reg;

  logic accept;
  logic last_lane;
  logic [DATA_W-1:0] wdata_lanes [LANES];

  assign accept    = Start_i & MemOp_i;
  assign last_lane = vec_reg ? (lane_cnt_reg == CNT_W'(LANES - 1)) : 1'b1;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign wdata_lanes[gi] = wdata_reg[lane_lsb(gi, DATA_W) +: DATA_W];
    end
  endgenerate

  // State register
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. DONE always returns to IDLE without looking at Start_i,
  // so a held Start_i is never re-accepted for the same instruction.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  if (last_lane) state_next = we_reg ? DONE : DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    DMemAddr_o     = '0;
    DMemWE_o       = 1'b0;
    DMemRE_o       = 1'b0;
    DMemWData_o    = '0;
    Mem_Finished_o = 1'b0;
    case (state_reg)
      IDLE: begin
        Mem_Finished_o = ~accept;
      end
      ACCESS: begin
        // Sum is truncated to ADDR_W bits, so addresses wrap.
        DMemAddr_o  = addr_reg + ADDR_W'(lane_cnt_reg);
        DMemWE_o    = we_reg;
        DMemRE_o    = ~we_reg;
        DMemWData_o = wdata_lanes[lane_cnt_reg];
      end
      DONE: begin
        Mem_Finished_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand latch, lane counter and load capture
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      lane_cnt_reg   <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      we_reg         <= 1'b0;
      vec_reg        <= 1'b0;
      rdata_reg      <= '0;
      cap_pend_reg   <= 1'b0;
      cap_lane_reg   <= '0;
      cap_scalar_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && accept) begin
        addr_reg     <= Addr_i;
        wdata_reg    <= WData_i;
        we_reg       <= MemWE_i;
        vec_reg      <= Vector_i;
        lane_cnt_reg <= '0;
      end else if (state_reg == ACCESS) begin
        lane_cnt_reg <= last_lane ? '0 : lane_cnt_reg + 1'b1;
      end

      cap_pend_reg   <= (state_reg == ACCESS) & ~we_reg;
      cap_lane_reg   <= lane_cnt_reg;
      cap_scalar_reg <= ~vec_reg;

      // A scalar load zero-fills the upper lanes in the same cycle that it
      // captures lane 0.
      if (cap_pend_reg) begin
        for (int k = 0; k < LANES; k++) begin
          if (cap_lane_reg == CNT_W'(k)) begin
            rdata_reg[lane_lsb(k, DATA_W) +: DATA_W] <= DMemRData_i;
          end else if (cap_scalar_reg) begin
            rdata_reg[lane_lsb(k, DATA_W) +: DATA_W] <= '0;
          end
        end
      end
    end
  end

  assign RData_o = rdata_reg;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed testbench for vector_mem_sequencer (LANES=4, DATA_W=8, ADDR_W=16).
// Expected memory strobes are queued when an instruction is driven and are
// popped and compared by a negedge monitor whenever the DUT strobes memory.
module tb_vector_mem_sequencer;
  import vec_mem_pkg::*;

  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;

  logic                    clk = 1'b0;
  logic                    Rst_i;
  logic                    Start_i;
  logic                    MemOp_i;
  logic                    MemWE_i;
  logic                    Vector_i;
  logic [ADDR_W-1:0]       Addr_i;
  logic [LANES*DATA_W-1:0] WData_i;
  logic [ADDR_W-1:0]       DMemAddr_o;
  logic                    DMemWE_o;
  logic                    DMemRE_o;
  logic [DATA_W-1:0]       DMemWData_o;
  logic [DATA_W-1:0]       DMemRData_i;
  logic [LANES*DATA_W-1:0] RData_o;
  logic                    Mem_Finished_o;

  always #5 clk = ~clk;

  vector_mem_sequencer #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .Clk_i         (clk),
    .Rst_i         (Rst_i),
    .Start_i       (Start_i),
    .MemOp_i       (MemOp_i),
    .MemWE_i       (MemWE_i),
    .Vector_i      (Vector_i),
    .Addr_i        (Addr_i),
    .WData_i       (WData_i),
    .DMemAddr_o    (DMemAddr_o),
    .DMemWE_o      (DMemWE_o),
    .DMemRE_o      (DMemRE_o),
    .DMemWData_o   (DMemWData_o),
    .DMemRData_i   (DMemRData_i),
    .RData_o       (RData_o),
    .Mem_Finished_o(Mem_Finished_o)
  );

  typedef struct packed {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [7:0]  data;
  } strobe_t;

  strobe_t exp_q[$];
  int      checks = 0;
  int      errors = 0;
  logic [7:0] mem [0:65535];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single-port data memory with registered read; preloaded during reset.
  always @(posedge clk) begin
    if (Rst_i) begin
      DMemRData_i   <= 8'h00;
      mem[16'h0020] <= 8'hA0;
      mem[16'h0021] <= 8'hA1;
      mem[16'h0022] <= 8'hA2;
      mem[16'h0023] <= 8'hA3;
      mem[16'h0030] <= 8'hB0;
      mem[16'h0031] <= 8'hB1;
      mem[16'h0032] <= 8'hB2;
      mem[16'h0033] <= 8'hB3;
      mem[16'hFFFE] <= 8'h5C;
    end else begin
      if (DMemWE_o) mem[DMemAddr_o] <= DMemWData_o;
      if (DMemRE_o) DMemRData_i <= mem[DMemAddr_o];
    end
  end

  // Strobe scoreboard
  always @(negedge clk) begin
    strobe_t got;
    strobe_t want;
    if (DMemWE_o === 1'b1 || DMemRE_o === 1'b1) begin
      got = {DMemWE_o, DMemRE_o, DMemAddr_o, DMemWData_o};
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 64'(got), 64'h0);
      end else begin
        want = exp_q.pop_front();
        chk("strobe", 64'(got), 64'(want));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction in the current (IDLE) cycle and walks it to DONE.
  // Operand inputs are scrambled while busy; they must be ignored.
  task automatic run_op(input logic we, input logic vec, input logic [15:0] addr,
                        input logic [31:0] wd, input logic hold, input logic [31:0] exp_rd);
    int n;
    int busy;
    logic [15:0] a;
    n    = vec ? LANES : 1;
    busy = n + (we ? 0 : 1);
    Start_i  = 1'b1;
    MemOp_i  = 1'b1;
    MemWE_i  = we;
    Vector_i = vec;
    Addr_i   = addr;
    WData_i  = wd;
    for (int l = 0; l < n; l++) begin
      a = addr + 16'(l);
      exp_q.push_back({we, ~we, a, wd[l*8 +: 8]});
    end
    $display("txn %s %s addr=%h wdata=%h hold=%0d", we ? "store" : "load",
             vec ? "vector" : "scalar", addr, wd, hold);
    #1 chk("accept_mf", 64'(Mem_Finished_o), 64'd0);
    step();
    if (!hold) Start_i = 1'b0;
    Addr_i   = ~addr;
    WData_i  = ~wd;
    MemWE_i  = ~we;
    Vector_i = ~vec;
    for (int i = 0; i < busy; i++) begin
      #1 chk("busy_mf", 64'(Mem_Finished_o), 64'd0);
      step();
    end
    #1 chk("done_mf", 64'(Mem_Finished_o), 64'd1);
    chk("done_state", 64'(dut.state_reg), 64'(DONE));
    if (!we) chk("rdata", 64'(RData_o), 64'(exp_rd));
  endtask

  initial begin
    Rst_i    = 1'b1;
    Start_i  = 1'b0;
    MemOp_i  = 1'b0;
    MemWE_i  = 1'b0;
    Vector_i = 1'b0;
    Addr_i   = '0;
    WData_i  = '0;
    step();
    step();
    chk("rst_rdata", 64'(RData_o), 64'd0);
    chk("rst_mf", 64'(Mem_Finished_o), 64'd1);
    chk("rst_strobes", 64'({DMemWE_o, DMemRE_o}), 64'd0);
    chk("rst_addr", 64'(DMemAddr_o), 64'd0);
    chk("rst_state", 64'(dut.state_reg), 64'(IDLE));
    Rst_i = 1'b0;

    // Non-memory instructions pass straight through.
    Start_i = 1'b1;
    MemOp_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      $display("txn non-memory cycle %0d", i);
      #1 chk("nonmem_mf", 64'(Mem_Finished_o), 64'd1);
      chk("nonmem_strobes", 64'({DMemWE_o, DMemRE_o}), 64'd0);
      step();
    end
    Start_i = 1'b0;

    run_op(1'b1, 1'b1, 16'h0010, 32'h44332211, 1'b0, 32'h0);
    step();
    chk("mem_0013", 64'(mem[16'h0013]), 64'h44);

    run_op(1'b0, 1'b1, 16'h0020, 32'h0, 1'b0, 32'hA3A2A1A0);
    step();
    chk("rdata_hold", 64'(RData_o), 64'hA3A2A1A0);

    run_op(1'b0, 1'b0, 16'hFFFE, 32'h0, 1'b0, 32'h0000005C);
    step();

    run_op(1'b1, 1'b1, 16'hFFFE, 32'hD4C3B2A1, 1'b0, 32'h0);
    step();
    chk("mem_0001", 64'(mem[16'h0001]), 64'hD4);

    run_op(1'b1, 1'b0, 16'h0040, 32'h000000EE, 1'b0, 32'h0);
    step();

    // Back-to-back vector loads with Start_i held.
    run_op(1'b0, 1'b1, 16'h0020, 32'h0, 1'b1, 32'hA3A2A1A0);
    step();
    chk("b2b_idle_state", 64'(dut.state_reg), 64'(IDLE));
    run_op(1'b0, 1'b1, 16'h0030, 32'h0, 1'b0, 32'hB3B2B1B0);
    step();

    // Reset in the second ACCESS cycle of a vector store.
    $display("txn store vector addr=0100 wdata=ddccbbaa (reset mid-op)");
    Start_i  = 1'b1;
    MemOp_i  = 1'b1;
    MemWE_i  = 1'b1;
    Vector_i = 1'b1;
    Addr_i   = 16'h0100;
    WData_i  = 32'hDDCCBBAA;
    exp_q.push_back({1'b1, 1'b0, 16'h0100, 8'hAA});
    exp_q.push_back({1'b1, 1'b0, 16'h0101, 8'hBB});
    #1 chk("rst_op_accept_mf", 64'(Mem_Finished_o), 64'd0);
    step();
    Start_i = 1'b0;
    step();
    Rst_i = 1'b1;
    step();
    Rst_i = 1'b0;
    #1 chk("midrst_we", 64'(DMemWE_o), 64'd0);
    chk("midrst_re", 64'(DMemRE_o), 64'd0);
    chk("midrst_state", 64'(dut.state_reg), 64'(IDLE));
    chk("midrst_rdata", 64'(RData_o), 64'd0);
    chk("midrst_mf_idle", 64'(Mem_Finished_o), 64'd1);
    Start_i = 1'b1;
    MemOp_i = 1'b1;
    #1 chk("midrst_mf_req", 64'(Mem_Finished_o), 64'd0);
    Start_i = 1'b0;
    MemOp_i = 1'b0;
    step();
    step();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_mem_sequencer.md
Name: vector_mem_sequencer

Overview:
- Memory-stage sequencer that produces Mem_Finished, the memory-side "done" handshake consumed by the control unit's Finished logic.
- Serialises scalar and vector load/store instructions onto a single-port, lane-wide data memory, one lane per cycle.
- Holds Mem_Finished low while the access runs. The pipeline therefore stalls until every lane has completed.
- Non-memory instructions pass with Mem_Finished high and no added cycles.

Parameters:
- LANES, 4, number of vector lanes (>=2).
- DATA_W, 8, bits per lane element.
- ADDR_W, 16, data-memory address width.

Ports:
- Clk_i  in  1  clock.
- Rst_i  in  1  synchronous, active-high reset.
- Start_i  in  1  a memory-stage instruction is present this cycle.
- MemOp_i  in  1  the instruction is a load or store; when 0, Start_i is ignored.
- MemWE_i  in  1  1 = store, 0 = load; from the control unit's MemWE.
- Vector_i  in  1  1 = vector access of LANES elements, 0 = scalar access.
- Addr_i  in  ADDR_W  base address.
- WData_i  in  LANES*DATA_W  store data; lane k = [k*DATA_W +: DATA_W]; scalar uses lane 0.
- DMemAddr_o  out  ADDR_W  memory address.
- DMemWE_o  out  1  memory write enable.
- DMemRE_o  out  1  memory read enable.
- DMemWData_o  out  DATA_W  memory write data.
- DMemRData_i  in  DATA_W  read data, valid the cycle after DMemRE_o.
- RData_o  out  LANES*DATA_W  registered load result.
- Mem_Finished_o  out  1  memory stage complete; pipeline may advance.

Behaviour:
- States: IDLE, ACCESS, DRAIN, DONE.
- Acceptance:
  - In IDLE, Start_i & MemOp_i accepts the instruction.
  - Addr_i, WData_i, MemWE_i and Vector_i are latched, and LaneCnt is cleared to 0.
  - The state moves to ACCESS.
- ACCESS:
  - Drives DMemAddr_o = AddrReg + LaneCnt, taken modulo 2^ADDR_W, so addresses wrap.
  - DMemWE_o = WeReg and DMemRE_o = !WeReg.
  - DMemWData_o = lane LaneCnt of WDataReg.
  - One lane is issued per cycle. The last lane is LANES-1 for vector, 0 for scalar.
  - After the last lane: a load goes to DRAIN; a store goes to DONE.
- Load capture:
  - DMemRData_i is captured into lane k of RData_o at the end of the cycle after lane k issued.
  - DRAIN, one cycle, captures the final lane.
  - A scalar load writes lane 0 and clears lanes 1..LANES-1 to zero.
  - RData_o is stable throughout DONE and holds until the next load captures.
- DONE: lasts one cycle, then the state always returns to IDLE.
  - Start_i is not examined in DONE, so an instruction is never re-accepted.
  - The next instruction is sampled in the following IDLE cycle.
- Outside ACCESS: DMemAddr_o = 0, DMemWE_o = 0, DMemRE_o = 0, DMemWData_o = 0.
- Mem_Finished_o (combinational) = (state==DONE) | (state==IDLE & !(Start_i & MemOp_i)).
- Latency from the acceptance cycle, with Mem_Finished_o low during these cycles and high in the following DONE cycle:
  - Vector store: LANES cycles.
  - Vector load: LANES+1 cycles.
  - Scalar store: 1 cycle.
  - Scalar load: 2 cycles.
- Input changes while busy (ACCESS, DRAIN, DONE) are ignored; operands are latched at acceptance.
- Reset:
  - Values: state = IDLE, LaneCnt = 0, all latched operand registers = 0, RData_o = 0, memory strobes = 0.
  - Mid-operation reset aborts immediately. No strobe is issued in the cycle after reset.
  - Partially loaded lanes are discarded: RData_o is cleared to 0.
  - Mem_Finished_o follows the IDLE rule after reset.
- LaneCnt width is $clog2(LANES); it never exceeds LANES-1.

Decomposition:
- Package vec_mem_pkg holds:
  - the state enum typedef (IDLE, ACCESS, DRAIN, DONE);
  - default LANES/DATA_W/ADDR_W localparams;
  - a lane-slice helper function.
- Single module, no sub-module. Lane counter and capture logic are inline.

Test Plan (LANES=4, DATA_W=8):
- Non-memory: Start_i=1, MemOp_i=0 for 5 cycles -> Mem_Finished_o=1 every cycle; no DMem strobes.
- Vector store: Addr=0x0010, WData=0x44332211 -> DMemWE_o high for 4 cycles, addresses 0x10..0x13, data 11,22,33,44; Mem_Finished_o low 4 cycles, then high in DONE.
- Vector load: memory[0x20..0x23] = A0,A1,A2,A3 -> 4 RE cycles plus DRAIN; in DONE, RData_o = 0xA3A2A1A0 and Mem_Finished_o=1.
- Scalar load then wrap: Addr=0xFFFE scalar load returns 5C -> RData_o = 0x0000005C after 2 busy cycles. Then a vector store at 0xFFFE -> addresses FFFE, FFFF, 0000, 0001.
- Back-to-back: a vector load with Start_i held high, followed immediately by a second vector load -> exactly one DONE cycle and one IDLE cycle between them; the second is accepted in that IDLE cycle with no re-accept of the first.
- Reset mid-op: assert Rst_i at the 2nd ACCESS cycle of a vector store -> the next cycle has DMemWE_o=0, state IDLE, RData_o=0; Mem_Finished_o = !(Start_i & MemOp_i).
